// File: rtl/rs_age_issue_pkg.sv
// Shared definitions for the ALU reservation station: reserved encodings,
// default field widths and the entry payload layout.
package rs_age_issue_pkg;

  localparam int RS_OP_W   = 6;
  localparam int RS_DATA_W = 32;
  localparam int RS_TAG_W  = 4;

  localparam int unsigned NOP_OP       = 0;
  localparam int unsigned ZERO_ROB_TAG = 0;

  // Payload of one station entry at the default widths
  typedef struct packed {
    logic [RS_OP_W-1:0]   op;
    logic [RS_DATA_W-1:0] pc;
    logic [RS_DATA_W-1:0] imm;
    logic [RS_TAG_W-1:0]  reorder;
    logic [RS_TAG_W-1:0]  tag_rs1;
    logic [RS_DATA_W-1:0] value_rs1;
    logic [RS_TAG_W-1:0]  tag_rs2;
    logic [RS_DATA_W-1:0] value_rs2;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Age-matrix oldest-ready selector: grants the ready entry that no other
// ready entry is older than. older[i][j] = entry i was allocated before j.
module rs_age_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]         ready,
  input  logic [N-1:0][N-1:0]  older,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  for (genvar gi = 0; gi < N; gi++) begin : g_col
    logic [N-1:0] blockers;

    always_comb begin
      blockers = '0;
      for (int j = 0; j < N; j++) begin
        blockers[j] = ready[j] & older[j][gi];
      end
    end

    assign grant[gi] = ready[gi] & ~(|blockers);
  end

  assign valid = |ready;

endmodule

// File: rtl/rs_age_issue.sv
// ALU reservation station: buffers dispatched instructions, snoops the CDB
// for operands and issues the oldest operand-complete entry per cycle.
module rs_age_issue
  import rs_age_issue_pkg::*;
#(
  parameter int RS_DEPTH  = 16,
  parameter int CDB_N     = 2,
  parameter int ROB_TAG_W = RS_TAG_W,
  parameter int DATA_W    = RS_DATA_W,
  parameter int OP_W      = RS_OP_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic [ROB_TAG_W-1:0]        in_decode_reorder,
  input  logic [OP_W-1:0]             in_decode_op,
  input  logic [DATA_W-1:0]           in_decode_pc,
  input  logic [DATA_W-1:0]           in_decode_imm,
  input  logic [DATA_W-1:0]           in_decode_value_rs1,
  input  logic [DATA_W-1:0]           in_decode_value_rs2,
  input  logic [ROB_TAG_W-1:0]        in_decode_reorder_rs1,
  input  logic [ROB_TAG_W-1:0]        in_decode_reorder_rs2,
  input  logic [CDB_N*ROB_TAG_W-1:0]  in_cdb_reorder,
  input  logic [CDB_N*DATA_W-1:0]     in_cdb_value,
  input  logic                        in_rs_misbranch,
  output logic                        out_fetcher_idle,
  output logic                        out_alu_valid,
  input  logic                        in_alu_ready,
  output logic [OP_W-1:0]             out_alu_op,
  output logic [DATA_W-1:0]           out_alu_pc,
  output logic [DATA_W-1:0]           out_alu_imm,
  output logic [DATA_W-1:0]           out_alu_value_rs1,
  output logic [DATA_W-1:0]           out_alu_value_rs2,
  output logic [ROB_TAG_W-1:0]        out_alu_reorder
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam logic [ROB_TAG_W-1:0] TAG_NONE = ROB_TAG_W'(ZERO_ROB_TAG);
  localparam logic [OP_W-1:0]      OP_NOP   = OP_W'(NOP_OP);

  logic [RS_DEPTH-1:0]               busy_reg;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_reg;
  logic [OP_W-1:0]      op_reg   [RS_DEPTH];
  logic [DATA_W-1:0]    pc_reg   [RS_DEPTH];
  logic [DATA_W-1:0]    imm_reg  [RS_DEPTH];
  logic [ROB_TAG_W-1:0] rob_reg  [RS_DEPTH];
  logic [DATA_W-1:0]    val1_reg [RS_DEPTH];
  logic [DATA_W-1:0]    val2_reg [RS_DEPTH];
  logic [ROB_TAG_W-1:0] tag1_reg [RS_DEPTH];
  logic [ROB_TAG_W-1:0] tag2_reg [RS_DEPTH];

  logic [DATA_W-1:0]    val1_next [RS_DEPTH];
  logic [DATA_W-1:0]    val2_next [RS_DEPTH];
  logic [ROB_TAG_W-1:0] tag1_next [RS_DEPTH];
  logic [ROB_TAG_W-1:0] tag2_next [RS_DEPTH];

  logic [ROB_TAG_W-1:0] cdb_tag [CDB_N];
  logic [DATA_W-1:0]    cdb_val [CDB_N];

  logic                 alu_valid_reg;
  logic [OP_W-1:0]      alu_op_reg;
  logic [DATA_W-1:0]    alu_pc_reg, alu_imm_reg, alu_val1_reg, alu_val2_reg;
  logic [ROB_TAG_W-1:0] alu_rob_reg;

  logic [RS_DEPTH-1:0]  entry_ready, grant;
  logic                 sel_valid, free_valid, dispatch_fire, issue_load;
  logic [IDX_W-1:0]     sel_idx, free_idx;
  logic [DATA_W-1:0]    disp_val1, disp_val2;
  logic [ROB_TAG_W-1:0] disp_tag1, disp_tag2;

  for (genvar gi = 0; gi < CDB_N; gi++) begin : g_cdb
    assign cdb_tag[gi] = in_cdb_reorder[gi*ROB_TAG_W +: ROB_TAG_W];
    assign cdb_val[gi] = in_cdb_value[gi*DATA_W +: DATA_W];
  end

  // Readiness uses registered tags only, so a wakeup becomes eligible next cycle
  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_ready
    assign entry_ready[gi] = busy_reg[gi] && tag1_reg[gi] == TAG_NONE
                             && tag2_reg[gi] == TAG_NONE;
  end

  rs_age_select #(.N(RS_DEPTH)) u_select (
    .ready (entry_ready),
    .older (older_reg),
    .grant (grant),
    .valid (sel_valid)
  );

  // Channels are scanned high to low so the lowest matching channel wins
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      val1_next[i] = val1_reg[i];
      tag1_next[i] = tag1_reg[i];
      val2_next[i] = val2_reg[i];
      tag2_next[i] = tag2_reg[i];
      for (int k = CDB_N - 1; k >= 0; k--) begin
        if (tag1_reg[i] != TAG_NONE && cdb_tag[k] == tag1_reg[i]) begin
          val1_next[i] = cdb_val[k];
          tag1_next[i] = TAG_NONE;
        end
        if (tag2_reg[i] != TAG_NONE && cdb_tag[k] == tag2_reg[i]) begin
          val2_next[i] = cdb_val[k];
          tag2_next[i] = TAG_NONE;
        end
      end
    end
  end

  always_comb begin
    disp_val1 = in_decode_value_rs1;
    disp_tag1 = in_decode_reorder_rs1;
    disp_val2 = in_decode_value_rs2;
    disp_tag2 = in_decode_reorder_rs2;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (in_decode_reorder_rs1 != TAG_NONE && cdb_tag[k] == in_decode_reorder_rs1) begin
        disp_val1 = cdb_val[k];
        disp_tag1 = TAG_NONE;
      end
      if (in_decode_reorder_rs2 != TAG_NONE && cdb_tag[k] == in_decode_reorder_rs2) begin
        disp_val2 = cdb_val[k];
        disp_tag2 = TAG_NONE;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  assign free_valid    = ~(&busy_reg);
  assign dispatch_fire = in_decode_reorder != TAG_NONE && free_valid;
  assign issue_load    = !alu_valid_reg || in_alu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= '0;
      older_reg     <= '0;
      alu_valid_reg <= 1'b0;
      alu_op_reg    <= OP_NOP;
      alu_rob_reg   <= TAG_NONE;
      alu_pc_reg    <= '0;
      alu_imm_reg   <= '0;
      alu_val1_reg  <= '0;
      alu_val2_reg  <= '0;
    end else if (rdy) begin
      if (in_rs_misbranch) begin
        busy_reg      <= '0;
        older_reg     <= '0;
        alu_valid_reg <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          val1_reg[i] <= val1_next[i];
          tag1_reg[i] <= tag1_next[i];
          val2_reg[i] <= val2_next[i];
          tag2_reg[i] <= tag2_next[i];
        end
        if (issue_load) begin
          alu_valid_reg <= sel_valid;
          if (sel_valid) begin
            alu_op_reg        <= op_reg[sel_idx];
            alu_pc_reg        <= pc_reg[sel_idx];
            alu_imm_reg       <= imm_reg[sel_idx];
            alu_rob_reg       <= rob_reg[sel_idx];
            alu_val1_reg      <= val1_reg[sel_idx];
            alu_val2_reg      <= val2_reg[sel_idx];
            busy_reg[sel_idx] <= 1'b0;
          end
        end
        // New entry is younger than every entry still busy before this edge
        if (dispatch_fire) begin
          busy_reg[free_idx]  <= 1'b1;
          op_reg[free_idx]    <= in_decode_op;
          pc_reg[free_idx]    <= in_decode_pc;
          imm_reg[free_idx]   <= in_decode_imm;
          rob_reg[free_idx]   <= in_decode_reorder;
          val1_reg[free_idx]  <= disp_val1;
          tag1_reg[free_idx]  <= disp_tag1;
          val2_reg[free_idx]  <= disp_val2;
          tag2_reg[free_idx]  <= disp_tag2;
          older_reg[free_idx] <= '0;
          for (int j = 0; j < RS_DEPTH; j++) begin
            if (busy_reg[j]) older_reg[j][free_idx] <= 1'b1;
          end
        end
      end
    end
  end

  assign out_fetcher_idle  = free_valid;
  assign out_alu_valid     = alu_valid_reg;
  assign out_alu_op        = alu_op_reg;
  assign out_alu_pc        = alu_pc_reg;
  assign out_alu_imm       = alu_imm_reg;
  assign out_alu_value_rs1 = alu_val1_reg;
  assign out_alu_value_rs2 = alu_val2_reg;
  assign out_alu_reorder   = alu_rob_reg;

endmodule

// File: doc/rs_age_issue.md
# rs_age_issue

Parametrised reservation station for the out-of-order core, sitting between decode and the ALU. It buffers up to RS_DEPTH dispatched ALU instructions and captures operands from CDB_N result-broadcast channels. Each cycle it issues the oldest operand-complete entry through a registered valid/ready port to the ALU. All entries, including index 0, are usable; ROB tag 0 means "no producer / no instruction".

## Interface
Parameters:
- RS_DEPTH, 16: entries; power of two, 2..32
- CDB_N, 2: number of broadcast channels (ALU, load/store, ...)
- ROB_TAG_W, 4: ROB tag width; tag 0 reserved
- DATA_W, 32: operand/PC/immediate width
- OP_W, 6: internal opcode width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; 0 freezes all state and outputs
- in_decode_reorder  in  ROB_TAG_W  dispatch tag; nonzero = dispatch request
- in_decode_op  in  OP_W  opcode
- in_decode_pc  in  DATA_W  instruction PC
- in_decode_imm  in  DATA_W  immediate
- in_decode_value_rs1/rs2  in  DATA_W  operand values, valid when matching tag is 0
- in_decode_reorder_rs1/rs2  in  ROB_TAG_W  producer tags; 0 = value valid
- in_cdb_reorder  in  CDB_N*ROB_TAG_W  broadcast tags, channel k at [k*ROB_TAG_W +: ROB_TAG_W]; 0 = idle
- in_cdb_value  in  CDB_N*DATA_W  broadcast values, same packing
- in_rs_misbranch  in  1  flush
- out_fetcher_idle  out  1  combinational; 1 = at least one free entry
- out_alu_valid  out  1  issue register holds an instruction
- in_alu_ready  in  1  ALU accepts this cycle
- out_alu_op / out_alu_pc / out_alu_imm / out_alu_value_rs1 / out_alu_value_rs2 / out_alu_reorder  out  per field  issued instruction

## Operation
- Per entry: busy, op, pc, imm, reorder, rs1/rs2 value and tag.
- Entry ready = busy and both tags 0. Readiness is computed from registered state only, so an entry woken this cycle is eligible next cycle.
- Age matrix older[i][j] records entry i dispatched before entry j.
  - On allocation of entry f: row f is cleared and column f is set for every busy entry.
  - Selection: the ready entry that no other ready entry is older than.
- Issue register: loads when it is empty or in_alu_ready=1. The selected entry is copied in and its busy bit cleared in the same cycle. If nothing is ready, out_alu_valid becomes 0 on accept. While out_alu_valid=1 and in_alu_ready=0, the register and all its fields hold.
- Dispatch: accepted when in_decode_reorder!=0 and a free entry exists. The free entry is the lowest-index non-busy entry, taken from pre-edge state. A request made while full is dropped; upstream gates on out_fetcher_idle.
- Wakeup: for every busy entry and each channel k with a nonzero CDB tag equal to the entry's rs1/rs2 tag, capture the value and clear the tag. If several channels match, the lowest k wins.
- Dispatch bypass: decode operand tags are also compared against all CDB channels in the same cycle, so no broadcast is missed.
- Flush (in_rs_misbranch=1, rdy=1): all busy bits, the age matrix and out_alu_valid are cleared. Same-cycle dispatch and issue are discarded. Flush takes priority over every other event.
- Reset: busy=0, age matrix=0, out_alu_valid=0, out_alu_op=NOP, out_alu_reorder=0. Other output fields are don't-care.

## Timing
- Dispatch at edge N makes the entry eligible at N+1. If both operands are ready at dispatch, out_alu_valid=1 after edge N+1, giving 1-cycle dispatch-to-issue.
- CDB broadcast at edge N sets the entry ready at N+1 and issues at edge N+1.
- Throughput is one issue per cycle while in_alu_ready=1.
- A slot freed by issue at edge N is visible in out_fetcher_idle after N; the same edge cannot reuse it.
- rdy=0: no state change, including flush and reset-free behaviour; outputs hold.

## Structure
- The shared package holds the NOP opcode, ZERO_ROB_TAG, and a typedef/struct for the RS entry payload.
- Sub-module rs_age_select: parametrised age-matrix selector taking ready and older vectors and producing a one-hot grant plus a valid flag. It is reusable by the load/store buffer.
- The free-entry finder is an inline priority encoder.

## Test plan
- Reset, then dispatch tag 3 with both operand tags 0, rs1=5, rs2=7 → out_alu_valid=1 one cycle later with reorder=3, values 5/7. out_fetcher_idle stays 1.
- Dispatch tags 1,2,3 all waiting on ROB tag 9, then CDB ch1 broadcasts 9, value 0x55 → issues in order 1,2,3 on consecutive cycles, all rs1=0x55.
- Dispatch to fill RS_DEPTH entries with in_alu_ready=0 → out_fetcher_idle=0; an extra dispatch is dropped; issue fields hold stable for 5 cycles.
- Dispatch with rs2 tag 4 in the same cycle that CDB ch0 broadcasts tag 4, value 0xAB → entry ready without further broadcast; issues with rs2=0xAB.
- CDB ch0 and ch1 both broadcast tag 6 with values 1 and 2 → captured value is 1.
- Six busy entries with out_alu_valid=1, then assert in_rs_misbranch together with a dispatch → next cycle out_alu_valid=0, out_fetcher_idle=1, and no instruction ever issues from the dropped dispatch.
